// File: rtl/ofmap_accum_drain.sv
// Receive end of a systolic MAC column: accumulates NUM_TILES passes of partial sums
// into a DEPTH-entry buffer, then drains the finished ofmap values over valid/ready.
module ofmap_accum_drain #(
  parameter int OFMAP_WIDTH = 8,
  parameter int ACC_WIDTH   = 16,
  parameter int DEPTH       = 4,
  parameter int NUM_TILES   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   psum_valid,
  input  logic [OFMAP_WIDTH-1:0] psum_in,
  output logic                   busy,
  output logic                   ofmap_valid,
  output logic [ACC_WIDTH-1:0]   ofmap_data,
  input  logic                   ofmap_ready,
  output logic                   done
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TILE_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    wr_addr_q, rd_addr_q, rd_next;
  logic [TILE_W-1:0]    tile_q;
  logic [ACC_WIDTH-1:0] buf_mem [DEPTH];
  logic [ACC_WIDTH-1:0] psum_ext;
  logic                 accept, last_accept, xfer, last_xfer;

  assign psum_ext = ACC_WIDTH'(psum_in);
  assign rd_next  = rd_addr_q + 1'b1;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    last_accept = 1'b0;
    xfer        = 1'b0;
    last_xfer   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = ACCUM;
      end
      ACCUM: begin
        accept      = psum_valid;
        last_accept = psum_valid && (tile_q == LAST_TILE) && (wr_addr_q == LAST_ADDR);
        if (last_accept) state_d = DRAIN;
      end
      DRAIN: begin
        xfer      = ofmap_ready;
        last_xfer = ofmap_ready && (rd_addr_q == LAST_ADDR);
        if (last_xfer) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign ofmap_valid = (state_q == DRAIN);

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      tile_q     <= '0;
      ofmap_data <= '0;
      done       <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= last_xfer;
      if ((state_q == IDLE) && start) begin
        wr_addr_q <= '0;
        rd_addr_q <= '0;
        tile_q    <= '0;
      end
      if (accept) begin
        if (wr_addr_q == LAST_ADDR) begin
          wr_addr_q <= '0;
          tile_q    <= tile_q + 1'b1;
        end else begin
          wr_addr_q <= wr_addr_q + 1'b1;
        end
      end
      // Entry 0 is already final when the last psum (entry DEPTH-1) lands.
      if (last_accept) begin
        rd_addr_q  <= '0;
        ofmap_data <= buf_mem[0];
      end
      if (xfer && !last_xfer) begin
        rd_addr_q  <= rd_next;
        ofmap_data <= buf_mem[rd_next];
      end
    end
  end

  // NOTE: the buffer has no reset; tile 0 overwrites every entry before it is read.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (tile_q == '0) buf_mem[wr_addr_q] <= psum_ext;
      else              buf_mem[wr_addr_q] <= buf_mem[wr_addr_q] + psum_ext;
    end
  end

endmodule

// File: tb/tb_ofmap_accum_drain.sv
// Directed bench for ofmap_accum_drain: a queue-based model of the expected ofmap
// stream checked every cycle, plus literal expectations for each scenario.
module tb_ofmap_accum_drain;

  localparam int DEPTH     = 4;
  localparam int NUM_TILES = 2;
  localparam int ACC_WIDTH = 16;
  localparam int NPSUM     = DEPTH * NUM_TILES;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, psum_valid = 1'b0, ofmap_ready = 1'b1;
  logic [7:0]  psum_in = '0;
  logic        busy, ofmap_valid, done;
  logic [15:0] ofmap_data;

  logic        w_start = 1'b0, w_psum_valid = 1'b0, w_ready = 1'b1;
  logic [7:0]  w_psum_in = '0;
  logic        w_busy, w_valid, w_done;
  logic [8:0]  w_data;

  always #5 clk = ~clk;

  ofmap_accum_drain #(.OFMAP_WIDTH(8), .ACC_WIDTH(ACC_WIDTH), .DEPTH(DEPTH), .NUM_TILES(NUM_TILES)) dut (
    .clk(clk), .rst(rst), .start(start), .psum_valid(psum_valid), .psum_in(psum_in),
    .busy(busy), .ofmap_valid(ofmap_valid), .ofmap_data(ofmap_data),
    .ofmap_ready(ofmap_ready), .done(done));

  ofmap_accum_drain #(.OFMAP_WIDTH(8), .ACC_WIDTH(9), .DEPTH(4), .NUM_TILES(3)) dut_wrap (
    .clk(clk), .rst(rst), .start(w_start), .psum_valid(w_psum_valid), .psum_in(w_psum_in),
    .busy(w_busy), .ofmap_valid(w_valid), .ofmap_data(w_data),
    .ofmap_ready(w_ready), .done(w_done));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int exp_q[$];
  int cap_q[$];
  int cap_cyc[$];
  int pop_cnt = 0;
  bit done_next = 1'b0;
  bit prev_stall = 1'b0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  // Expected stream: the queue front must be presented whenever valid is high;
  // a job's done pulse follows the cycle in which its DEPTH-th value is accepted.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        exp_q.delete();
        pop_cnt    = 0;
        done_next  = 1'b0;
        prev_stall = 1'b0;
      end else begin
        check("done", done, done_next);
        done_next = 1'b0;
        if (ofmap_valid) begin
          check("busy_with_valid", busy, 1);
          if (exp_q.size() == 0) begin
            check("spurious_valid", ofmap_valid, 0);
          end else begin
            check("ofmap_data", ofmap_data, exp_q[0]);
            if (ofmap_ready) begin
              cap_q.push_back(int'(ofmap_data));
              cap_cyc.push_back(cyc);
              void'(exp_q.pop_front());
              pop_cnt++;
              if (pop_cnt == DEPTH) begin
                pop_cnt   = 0;
                done_next = 1'b1;
              end
            end
          end
        end else if (prev_stall) begin
          check("valid_held", ofmap_valid, 1);
        end
        prev_stall = ofmap_valid && !ofmap_ready;
      end
    end
  end

  task automatic feed_job(input int p[NPSUM], input bit bubbles, input bit stray_start);
    for (int a = 0; a < DEPTH; a++) begin
      int s = 0;
      for (int t = 0; t < NUM_TILES; t++) s += p[t*DEPTH + a];
      exp_q.push_back(s % (1 << ACC_WIDTH));
    end
    start = 1'b1; psum_valid = 1'b1; psum_in = 8'd99;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int i = 0; i < NPSUM; i++) begin
      if (bubbles) begin
        psum_valid = 1'b0; start = stray_start;
        tick();
        start = 1'b0;
      end
      psum_valid = 1'b1; psum_in = 8'(p[i]);
      tick();
    end
    psum_valid = 1'b0;
    check("first_valid_latency", ofmap_valid, 1);
  endtask

  task automatic finish_job();
    int c = 0;
    while (!done && c < 60) begin
      tick();
      c++;
    end
    check("done_reached", done, 1);
    tick();
    check("done_single_pulse", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  task automatic check_capture(input string name, input int span);
    int lit[4] = '{11, 22, 33, 44};
    check({name, "_count"}, cap_q.size(), 4);
    for (int i = 0; i < 4 && i < cap_q.size(); i++) check({name, "_value"}, cap_q[i], lit[i]);
    if (cap_cyc.size() == 4) check({name, "_span"}, cap_cyc[3] - cap_cyc[0], span);
    cap_q.delete();
    cap_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int basic[NPSUM] = '{1, 2, 3, 4, 10, 20, 30, 40};

    // 1: reset state, then reset again in the middle of random stimulus
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_valid", ofmap_valid, 0);
    check("rst_done", done, 0);
    check("rst_data", ofmap_data, 0);
    check("rst_w_data", w_data, 0);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      start = 1'($urandom_range(0, 1));
      psum_valid = 1'($urandom_range(0, 1));
      psum_in = 8'($urandom_range(0, 255));
      ofmap_ready = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("midrst_busy", busy, 0);
      check("midrst_valid", ofmap_valid, 0);
      check("midrst_done", done, 0);
      check("midrst_data", ofmap_data, 0);
    end
    rst = 1'b0; start = 1'b0; psum_valid = 1'b0; ofmap_ready = 1'b1;
    tick();
    mon_en = 1'b1;

    // 2: basic job at full throughput
    feed_job(basic, 1'b0, 1'b0);
    finish_job();
    check_capture("basic", 3);

    // 3: backpressure while 22 is presented
    feed_job(basic, 1'b0, 1'b0);
    tick();
    ofmap_ready = 1'b0;
    repeat (3) tick();
    check("bp_hold_valid", ofmap_valid, 1);
    check("bp_hold_data", ofmap_data, 22);
    ofmap_ready = 1'b1;
    finish_job();
    check_capture("backpressure", 6);

    // 4: psum bubbles with stray start pulses during ACCUM
    feed_job(basic, 1'b1, 1'b1);
    finish_job();
    check_capture("bubbles", 3);

    // 5: accumulator wrap, 3 tiles of 255 into 9 bits
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      w_psum_valid = 1'b1; w_psum_in = 8'd255;
      tick();
    end
    w_psum_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("wrap_valid", w_valid, 1);
      check("wrap_data", w_data, 253);
      tick();
    end
    check("wrap_done", w_done, 1);
    check("wrap_valid_drop", w_valid, 0);

    // 6: abort after 5 accepted psums, then a clean job
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      psum_valid = 1'b1; psum_in = 8'(basic[i] + 100);
      tick();
    end
    psum_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", ofmap_valid, 0);
    check("abort_done", done, 0);
    repeat (4) tick();
    check("abort_stays_idle", busy, 0);
    feed_job(basic, 1'b0, 1'b0);
    finish_job();
    check_capture("restart", 3);

    check("model_queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
